mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single memory read/write port between the instruction cache refill path and the data cache. It has one outstanding transaction at a time: it latches the winning request, drives it to memory until accepted, then waits for the response and routes it back to the owner. A watchdog counter bounds the wait and returns an error response if memory never answers.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before a forced error response, range 1..65535.
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width. The strobe width is DATA_W/8.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `ic_req` in 1: icache read request, held until `ic_gnt`.
- `ic_addr` in ADDR_W: icache read address.
- `ic_gnt` out 1: icache request accepted this cycle.
- `ic_rvalid` out 1: icache response valid, one-cycle pulse.
- `ic_rdata` out DATA_W: icache response data.
- `dc_req` in 1: dcache request, held until `dc_gnt`.
- `dc_we` in 1: 1 selects write, 0 selects read.
- `dc_addr` in ADDR_W: dcache address.
- `dc_wdata` in DATA_W: dcache write data.
- `dc_wstrb` in DATA_W/8: dcache byte strobes.
- `dc_gnt` out 1: dcache request accepted this cycle.
- `dc_rvalid` out 1: dcache response valid, one-cycle pulse. For writes this is the write acknowledge.
- `dc_rdata` out DATA_W: dcache read data. It is 0 for writes.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out: memory request bundle, driven from registers.
- `mem_gnt` in 1: memory accepts the request in the cycle where `mem_req` and `mem_gnt` are both 1.
- `mem_rvalid` in 1: memory response valid.
- `mem_rdata` in DATA_W: memory response data.
- `err_timeout` out 1: sticky flag, set by a watchdog expiry.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE
  - If either request is asserted, pick a winner.
  - Pulse the winner's `*_gnt` combinationally in the same cycle.
  - Latch the winner's address, we, wdata and wstrb plus the owner bit into the request buffer.
  - Go to REQ.
  - An icache request always latches `we`=0 and `wstrb`=0.
- REQ
  - `mem_req`=1 with the buffered fields.
  - On `mem_gnt`, go to WAIT and clear the watchdog counter.
  - Fields stay stable until accepted.
- WAIT
  - The watchdog counter increments each cycle.
  - On `mem_rvalid`, latch `mem_rdata` (0 if the transaction was a write) and go to RESP.
  - If the counter reaches TIMEOUT without `mem_rvalid`, latch 0, set `err_timeout`, and go to RESP.
  - If `mem_rvalid` arrives in the same cycle the counter reaches TIMEOUT, the response wins and `err_timeout` is not set.
- RESP
  - Pulse the owner's `*_rvalid` with the latched data.
  - Go to IDLE.
  - No grant is given in RESP, so there is one bubble between transactions.
- `mem_rvalid` outside WAIT is ignored.
- A request that drops before its grant is simply never served; no state is kept for it.
- After reset, outputs are:
  - all `*_gnt`, `*_rvalid`, `mem_req`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata`, `mem_wstrb`, `*_rdata` = 0;
  - `err_timeout` = 0;
  - state = IDLE.
- Reset asserted mid-transaction abandons the transaction: no response is pulsed and any late `mem_rvalid` is ignored.
- `err_timeout` clears only on reset.

## Timing
- A request seen in IDLE at cycle t:
  - `gnt` at t;
  - `mem_req` from t+1;
  - with an immediate `mem_gnt` at t+1, state is WAIT at t+2.
- `mem_rvalid` at cycle w gives the owner `rvalid` at w+1, and the next grant is possible at w+2.
- Minimum request-to-response latency is 4 cycles, with `mem_rvalid` at t+2.
- Watchdog: with no response, the error `rvalid` appears TIMEOUT+1 cycles after entering WAIT.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - A one-bit `last_owner` register updates on every grant.
  - On a simultaneous request, the requester not served last wins.
  - After reset `last_owner` = icache, so dcache wins the first tie.
- `MEM_ARB_RR_EN` not defined: fixed priority. dcache always wins ties and there is no `last_owner` register.
- A lone requester wins in both modes.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, RESP);
  - the owner encoding (OWN_IC=0, OWN_DC=1);
  - the default TIMEOUT constant.
- Sub-module `rr_arb2`: a combinational 2-way chooser taking both requests and `last_owner`. The `MEM_ARB_RR_EN` macro is resolved inside it.
- The top level holds the FSM, the request buffer, the response register and the watchdog.

## Test plan
- Single icache read:
  - stimulus: `ic_req`, addr 0x8000_0010; memory grants immediately and returns 0x1122334455667788 two cycles later;
  - required: `ic_gnt` at t, `mem_we`=0, `ic_rvalid` exactly once with that data, `dc_rvalid` never.
- dcache write:
  - stimulus: addr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0x0F;
  - required: `mem_we`=1 with the exact fields, `dc_rvalid` with `dc_rdata`=0.
- Simultaneous requests held for 4 transactions:
  - required with RR: grant order dc, ic, dc, ic;
  - required with fixed priority: icache starves until dcache drops its request.
- Backpressure:
  - stimulus: `mem_gnt` held low for 5 cycles;
  - required: `mem_req` and its fields stay stable across all 5 cycles, and no new grant is given.
- Watchdog:
  - stimulus: TIMEOUT=8, memory never responds;
  - required: owner `rvalid` with data 0 is 9 cycles after entering WAIT and `err_timeout`=1; a later normal transaction completes with `err_timeout` still 1.
- Reset in WAIT, then a late `mem_rvalid`:
  - required: no `*_rvalid`, all outputs at reset values, and the next request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the icache/dcache memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational 2-way chooser; MEM_ARB_RR_EN selects round-robin, else dcache-priority
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic winner
);

    assign grant_valid = ic_req | dc_req;

    // With no request the choice is a don't-care; it simply echoes last_owner.
    always_comb begin
        winner = last_owner;
        if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
            winner = ~last_owner;
`else
            winner = OWN_DC;
`endif
        end else if (dc_req) begin
            winner = OWN_DC;
        end else if (ic_req) begin
            winner = OWN_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding icache/dcache memory arbiter with watchdog; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_W-1:0]     ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic [DATA_W-1:0]     ic_rdata,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_W-1:0]     dc_addr,
    input  logic [DATA_W-1:0]     dc_wdata,
    input  logic [DATA_W/8-1:0]   dc_wstrb,
    output logic                  dc_gnt,
    output logic                  dc_rvalid,
    output logic [DATA_W-1:0]     dc_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err_timeout
);

    state_t              state, state_next;
    logic                owner;
    logic                last_owner;
    logic                arb_valid;
    logic                arb_winner;
    logic                wd_expire;
    logic [15:0]         wd_cnt;
    logic [DATA_W-1:0]   resp_data;

    rr_arb2 u_rr_arb2 (
        .ic_req      (ic_req),
        .dc_req      (dc_req),
        .last_owner  (last_owner),
        .grant_valid (arb_valid),
        .winner      (arb_winner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_IC;
        end else if (state == ST_IDLE && arb_valid) begin
            last_owner <= arb_winner;
        end
    end
`else
    assign last_owner = OWN_IC;
`endif

    assign wd_expire = (wd_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (arb_valid)               state_next = ST_REQ;
            ST_REQ:  if (mem_gnt)                 state_next = ST_WAIT;
            ST_WAIT: if (mem_rvalid || wd_expire) state_next = ST_RESP;
            ST_RESP:                              state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ic_gnt    = 1'b0;
        dc_gnt    = 1'b0;
        ic_rvalid = 1'b0;
        dc_rvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                ic_gnt = arb_valid && (arb_winner == OWN_IC);
                dc_gnt = arb_valid && (arb_winner == OWN_DC);
            end
            ST_RESP: begin
                ic_rvalid = (owner == OWN_IC);
                dc_rvalid = (owner == OWN_DC);
            end
            default: ;
        endcase
    end

    assign ic_rdata = resp_data;
    assign dc_rdata = resp_data;

    // Request buffer, response register and watchdog; a real response beats an expiring watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IC;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            wd_cnt      <= '0;
            resp_data   <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        owner   <= arb_winner;
                        mem_req <= 1'b1;
                        if (arb_winner == OWN_DC) begin
                            mem_we    <= dc_we;
                            mem_addr  <= dc_addr;
                            mem_wdata <= dc_wdata;
                            mem_wstrb <= dc_wstrb;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= ic_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        wd_cnt  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        resp_data <= mem_we ? '0 : mem_rdata;
                    end else if (wd_expire) begin
                        resp_data   <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
